// File: rtl/sha3_pkg.sv
// Shared constants and types for the SHA-3 input padder.
package sha3_pkg;

  localparam int RATE_BITS       = 1088;
  localparam int WORD_BITS       = 64;
  localparam int WORDS_PER_BLOCK = 17;
  localparam int CNT_W           = 5;

  localparam logic [7:0]       FINAL_PAD = 8'h80;
  localparam logic [CNT_W-1:0] LAST_IDX  = CNT_W'(WORDS_PER_BLOCK - 1);
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(WORDS_PER_BLOCK);

  // FILL: taking host words; PAD: self-inserting zero/final words; FULL: block held for f_permutation.
  typedef enum logic [1:0] {
    FILL = 2'd0,
    PAD  = 2'd1,
    FULL = 2'd2
  } sha3_state_e;

  // Observability bundle for the padder's internal state.
  typedef struct packed {
    sha3_state_e      state;
    logic [CNT_W-1:0] count;
    logic             done;
  } sha3_dbg_t;

endpackage

// File: rtl/sha3_pad_word.sv
// Builds the final message word: keeps bytes 0..n-1, puts the domain byte at
// byte n, zeroes the rest, and ORs the final 0x80 into byte 7 when this word
// is also the last word of the rate block.
module sha3_pad_word
  import sha3_pkg::*;
#(
  parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
  input  logic [WORD_BITS-1:0] word_i,
  input  logic [2:0]           byte_num_i,
  input  logic                 last_of_block_i,
  output logic [WORD_BITS-1:0] word_o
);

  int n;

  // Byte-wise select between message data, domain byte and zero fill.
  always_comb begin
    n      = int'(byte_num_i);
    word_o = '0;
    for (int b = 0; b < 8; b++) begin
      if (b < n) begin
        word_o[63-8*b -: 8] = word_i[63-8*b -: 8];
      end else if (b == n) begin
        word_o[63-8*b -: 8] = DOMAIN_PAD;
      end
    end
    if (last_of_block_i) begin
      word_o[7:0] = word_o[7:0] | FINAL_PAD;
    end
  end

endmodule

// File: rtl/sha3_padder.sv
// SHA-3 input padder: packs 64-bit host words into 1088-bit rate blocks,
// applies multi-rate padding to the last block of each message, and holds
// each completed block until f_permutation acknowledges it.
//
// Handshakes: a host word is transferred on a rising edge where
// in_ready=1 and buffer_full=0; the host must hold in/is_last/byte_num
// stable until that happens. A block is transferred to f_permutation on a
// rising edge where out_ready=1 and f_ack=1; f_ack while out_ready=0 is
// ignored.
module sha3_padder
  import sha3_pkg::*;
#(
  parameter logic [7:0] DOMAIN_PAD = 8'h06
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [WORD_BITS-1:0] in,
  input  logic                 in_ready,
  input  logic                 is_last,
  input  logic [2:0]           byte_num,
  output logic                 buffer_full,
  output logic [RATE_BITS-1:0] out,
  output logic                 out_ready,
  input  logic                 f_ack,
  output sha3_dbg_t            dbg_o
);

  sha3_state_e          state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 done_q,  done_d;
  logic [RATE_BITS-1:0] out_q,   out_d;

  logic                 shift_en;
  logic [WORD_BITS-1:0] shift_word;
  logic [WORD_BITS-1:0] padded_word;

  sha3_pad_word #(
    .DOMAIN_PAD (DOMAIN_PAD)
  ) u_pad_word (
    .word_i          (in),
    .byte_num_i      (byte_num),
    .last_of_block_i (count_q == LAST_IDX),
    .word_o          (padded_word)
  );

  // Next-state, word selection and block shifting.
  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    done_d     = done_q;
    out_d      = out_q;
    shift_en   = 1'b0;
    shift_word = '0;

    unique case (state_q)
      FILL: begin
        if (in_ready) begin
          shift_en = 1'b1;
          count_d  = count_q + 1'b1;
          if (is_last) begin
            shift_word = padded_word;
            done_d     = 1'b1;
            // Last word landing in slot 16 already carries the final bit.
            state_d    = (count_q == LAST_IDX) ? FULL : PAD;
          end else begin
            shift_word = in;
            if (count_q == LAST_IDX) begin
              state_d = FULL;
            end
          end
        end
      end

      PAD: begin
        shift_en = 1'b1;
        count_d  = count_q + 1'b1;
        if (count_q == LAST_IDX) begin
          shift_word = {{(WORD_BITS-8){1'b0}}, FINAL_PAD};
          state_d    = FULL;
        end
      end

      FULL: begin
        if (f_ack) begin
          state_d = FILL;
          count_d = '0;
          done_d  = 1'b0;
        end
      end

      default: begin
        state_d = FILL;
      end
    endcase

    if (shift_en) begin
      out_d = {out_q[RATE_BITS-WORD_BITS-1:0], shift_word};
    end
  end

  // State and block registers; reset discards any partial block.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FILL;
      count_q <= '0;
      done_q  <= 1'b0;
      out_q   <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      done_q  <= done_d;
      out_q   <= out_d;
    end
  end

  assign buffer_full = (state_q != FILL);
  assign out_ready   = (state_q == FULL);
  assign out         = out_q;

  assign dbg_o.state = state_q;
  assign dbg_o.count = count_q;
  assign dbg_o.done  = done_q;

  // count_q never exceeds a full block.
  initial_range_check: assert property (@(posedge clk) disable iff (reset) count_q <= FULL_CNT);

endmodule

// File: tb/tb_sha3_padder.sv
// Bench for sha3_padder: directed scenarios plus random messages, checked
// against a byte-level SHA-3 padding model and an expected-block queue.
module tb_sha3_padder;
  import sha3_pkg::*;

  localparam logic [7:0] DOMAIN = 8'h06;
  localparam logic [RATE_BITS-1:0] EMPTY_BLK = {64'h0600000000000000, 960'h0, 64'h0000000000000080};

  logic                 clk = 1'b0;
  logic                 reset;
  logic [63:0]          in;
  logic                 in_ready;
  logic                 is_last;
  logic [2:0]           byte_num;
  logic                 buffer_full;
  logic [RATE_BITS-1:0] out;
  logic                 out_ready;
  logic                 f_ack;
  logic                 cons_ack;
  logic                 tb_ack;
  sha3_dbg_t            dbg;

  assign f_ack = cons_ack | tb_ack;

  int checks = 0;
  int errors = 0;

  logic [RATE_BITS-1:0] exp_q[$];
  logic [7:0]           cur_bytes[$];
  bit                   hold_ack = 1'b0;
  int                   ack_max  = 3;

  sha3_padder #(
    .DOMAIN_PAD (DOMAIN)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .in          (in),
    .in_ready    (in_ready),
    .is_last     (is_last),
    .byte_num    (byte_num),
    .buffer_full (buffer_full),
    .out         (out),
    .out_ready   (out_ready),
    .f_ack       (f_ack),
    .dbg_o       (dbg)
  );

  // Clock
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic check_block(input string tag, input logic [RATE_BITS-1:0] got,
                             input logic [RATE_BITS-1:0] exp);
    for (int i = 0; i < WORDS_PER_BLOCK; i++) begin
      check($sformatf("%s_w%0d", tag, i), got[RATE_BITS-1-64*i -: 64], exp[RATE_BITS-1-64*i -: 64]);
    end
  endtask

  // Reference: message as a byte stream, padded as M || DOMAIN || 0* with 0x80 in the last rate byte.
  task automatic model_word(input logic [63:0] w, input logic last, input logic [2:0] n);
    int k;
    k = last ? int'(n) : 8;
    for (int b = 0; b < k; b++) cur_bytes.push_back(w[63-8*b -: 8]);
    if (last) begin
      cur_bytes.push_back(DOMAIN);
      while (cur_bytes.size() < RATE_BITS/8) cur_bytes.push_back(8'h00);
      cur_bytes[RATE_BITS/8-1] = cur_bytes[RATE_BITS/8-1] | 8'h80;
    end
    if (cur_bytes.size() == RATE_BITS/8) begin
      logic [RATE_BITS-1:0] blk;
      for (int b = 0; b < RATE_BITS/8; b++) blk[RATE_BITS-1-8*b -: 8] = cur_bytes[b];
      exp_q.push_back(blk);
      cur_bytes.delete();
    end
  endtask

  // Driver: present a word at a falling edge and hold it until the padder takes it.
  task automatic drive_word(input logic [63:0] w, input logic last, input logic [2:0] n);
    int guard;
    guard    = 0;
    in       = w;
    is_last  = last;
    byte_num = n;
    in_ready = 1'b1;
    while (buffer_full && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 200) check("accept_timeout", 64'(buffer_full), 64'(0));
    @(negedge clk);
    in_ready = 1'b0;
    is_last  = 1'b0;
  endtask

  task automatic put(input logic [63:0] w, input logic last, input logic [2:0] n);
    model_word(w, last, n);
    drive_word(w, last, n);
  endtask

  // Falling edges after the last word's acceptance until out_ready shows.
  task automatic wait_block(input string tag, input int exp_lat);
    int c;
    c = 0;
    while (!out_ready && c < 40) begin
      @(negedge clk);
      c++;
    end
    check({tag, "_lat"}, 64'(c), 64'(exp_lat));
  endtask

  task automatic wait_idle();
    int c;
    c = 0;
    while ((exp_q.size() != 0 || out_ready) && c < 400) begin
      @(negedge clk);
      c++;
    end
    check("idle_timeout", 64'(c >= 400), 64'(0));
  endtask

  // Scoreboard / consumer: compare each presented block, then acknowledge it.
  initial begin
    cons_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset && out_ready && !hold_ack) begin
        if (exp_q.size() == 0) check("unexpected_block", 64'(out_ready), 64'(0));
        else check_block("block", out, exp_q.pop_front());
        repeat ($urandom_range(0, ack_max)) @(negedge clk);
        cons_ack = 1'b1;
        @(negedge clk);
        cons_ack = 1'b0;
        check("ack_ready_low", 64'(out_ready), 64'(0));
        check("ack_bf_low", 64'(buffer_full), 64'(0));
      end
    end
  end

  // Stimulus
  initial begin
    logic [63:0] w;
    int          j;
    reset    = 1'b1;
    in       = '0;
    in_ready = 1'b0;
    is_last  = 1'b0;
    byte_num = '0;
    tb_ack   = 1'b0;
    repeat (3) @(negedge clk);

    check("rst_out_hi", out[RATE_BITS-1 -: 64], 64'(0));
    check("rst_out_lo", out[63:0], 64'(0));
    check("rst_ready", 64'(out_ready), 64'(0));
    check("rst_bf", 64'(buffer_full), 64'(0));
    check("rst_count", 64'(dbg.count), 64'(0));
    check("rst_done", 64'(dbg.done), 64'(0));
    reset = 1'b0;
    @(negedge clk);

    // Empty message: only the domain byte plus the final bit.
    put({$urandom, $urandom}, 1'b1, 3'd0);
    check("empty_pad_bf", 64'(buffer_full), 64'(1));
    check("empty_done", 64'(dbg.done), 64'(1));
    wait_block("empty", 16);
    check_block("empty_const", out, EMPTY_BLK);
    check("empty_bf", 64'(buffer_full), 64'(1));

    // Last word in slot 16 with 7 bytes: domain and final bit share byte 7.
    wait_idle();
    for (int i = 0; i < 16; i++) put(64'h0101010101010101, 1'b0, 3'($urandom_range(0, 7)));
    put(64'hAABBCCDDEEFF1122, 1'b1, 3'd7);
    wait_block("slot16", 0);
    check("slot16_word", out[63:0], 64'hAABBCCDDEEFF1186);

    // Full block held; a pending host word is refused until the ack.
    wait_idle();
    hold_ack = 1'b1;
    for (int i = 0; i < 17; i++) put({$urandom, $urandom}, 1'b0, 3'd0);
    check("full_ready", 64'(out_ready), 64'(1));
    check("full_bf", 64'(buffer_full), 64'(1));
    w = 64'h1122334455667788;
    model_word(w, 1'b1, 3'd3);
    in = w; is_last = 1'b1; byte_num = 3'd3; in_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("hold_bf", 64'(buffer_full), 64'(1));
      check("hold_out", out[63:0], exp_q[0][63:0]);
      check("hold_count", 64'(dbg.count), 64'(17));
    end
    hold_ack = 1'b0;
    drive_word(w, 1'b1, 3'd3);
    check("new_w0", out[63:0], 64'h1122330600000000);
    check("new_count", 64'(dbg.count), 64'(1));
    wait_block("after_full", 16);
    check("final_w16", out[63:0], 64'h0000000000000080);

    // Stray f_ack during FILL has no effect.
    wait_idle();
    for (int i = 0; i < 5; i++) put({$urandom, $urandom}, 1'b0, 3'd0);
    check("stray_count_a", 64'(dbg.count), 64'(5));
    tb_ack = 1'b1;
    @(negedge clk);
    tb_ack = 1'b0;
    check("stray_count_b", 64'(dbg.count), 64'(5));
    check("stray_ready", 64'(out_ready), 64'(0));
    check("stray_bf", 64'(buffer_full), 64'(0));
    put({$urandom, $urandom}, 1'b0, 3'd0);
    check("stray_count_c", 64'(dbg.count), 64'(6));
    put({$urandom, $urandom}, 1'b1, 3'($urandom_range(0, 7)));
    wait_block("stray", 10);

    // Asynchronous reset in the middle of PAD.
    wait_idle();
    for (int i = 0; i < 7; i++) put({$urandom, $urandom}, 1'b0, 3'd0);
    put({$urandom, $urandom}, 1'b1, 3'($urandom_range(0, 7)));
    check("pad_count", 64'(dbg.count), 64'(8));
    check("pad_bf", 64'(buffer_full), 64'(1));
    #2 reset = 1'b1;
    #1;
    check("arst_out_hi", out[RATE_BITS-1 -: 64], 64'(0));
    check("arst_out_lo", out[63:0], 64'(0));
    check("arst_ready", 64'(out_ready), 64'(0));
    check("arst_bf", 64'(buffer_full), 64'(0));
    check("arst_count", 64'(dbg.count), 64'(0));
    exp_q.delete();
    cur_bytes.delete();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    put({$urandom, $urandom}, 1'b1, 3'd0);
    wait_block("post_rst", 16);
    check_block("post_rst_const", out, EMPTY_BLK);

    // Random messages with random gaps and ack delays.
    for (int m = 0; m < 25; m++) begin
      int nfull;
      nfull   = $urandom_range(0, 40);
      ack_max = $urandom_range(0, 4);
      for (int i = 0; i < nfull; i++) begin
        put({$urandom, $urandom}, 1'b0, 3'($urandom_range(0, 7)));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
      j = cur_bytes.size() / 8;
      put({$urandom, $urandom}, 1'b1, 3'($urandom_range(0, 7)));
      wait_block("rand", 16 - j);
    end

    wait_idle();
    check("drain", 64'(exp_q.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
